// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word assembler: one bit per cycle in over valid/ready,
// WIDTH-bit word out through a one-entry register with its own valid/ready.
module serial_word_deserializer #(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sin_valid,
  input  logic             sin_data,
  output logic             sin_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic             dout_valid_reg, dout_valid_next;
  logic [WIDTH-1:0] shifted;
  logic             accept;
  logic             consume;
  logic             load;

  // Bit order only changes which end of the register the new bit enters.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shift_reg[WIDTH-2:0], sin_data};
    end else begin : g_lsb_first
      assign shifted = {sin_data, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  assign accept  = sin_valid && sin_ready;
  assign consume = dout_valid_reg && dout_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= COLLECT;
      count_reg      <= '0;
      shift_reg      <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      shift_reg      <= shift_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    shift_next = shift_reg;
    dout_next  = dout_reg;
    load       = 1'b0;

    case (state_reg)
      COLLECT: begin
        if (clr) begin
          count_next = '0;
          shift_next = '0;
        end else if (accept) begin
          if (count_reg == LAST_IDX) begin
            if (!dout_valid_reg || consume) begin
              dout_next  = shifted;
              load       = 1'b1;
              count_next = '0;
              shift_next = '0;
            end else begin
              // Output still occupied: park the finished word here.
              shift_next = shifted;
              state_next = STALL;
            end
          end else begin
            shift_next = shifted;
            count_next = count_reg + CW'(1);
          end
        end
      end
      STALL: begin
        if (clr) begin
          state_next = COLLECT;
          count_next = '0;
          shift_next = '0;
        end else if (consume) begin
          dout_next  = shift_reg;
          load       = 1'b1;
          count_next = '0;
          shift_next = '0;
          state_next = COLLECT;
        end
      end
      default: begin
        state_next = COLLECT;
        count_next = '0;
        shift_next = '0;
      end
    endcase

    // A word loading on the same edge as a consume keeps dout_valid high.
    dout_valid_next = load ? 1'b1 : (consume ? 1'b0 : dout_valid_reg);
  end

  // Outputs
  always_comb begin
    sin_ready  = (state_reg == COLLECT);
    busy       = (count_reg != '0) || (state_reg == STALL);
    dout       = dout_reg;
    dout_valid = dout_valid_reg;
  end

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Bench for serial_word_deserializer: MSB-first and LSB-first instances share
// stimulus; a queue-based model predicts words and handshake status.
module tb_serial_word_deserializer;

  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic sin_valid = 1'b0;
  logic sin_data = 1'b0;
  logic dout_ready = 1'b0;

  logic         sin_ready_a, dout_valid_a, busy_a;
  logic [W-1:0] dout_a;
  logic         sin_ready_b, dout_valid_b, busy_b;
  logic [W-1:0] dout_b;

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .sin_valid(sin_valid), .sin_data(sin_data), .sin_ready(sin_ready_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready),
    .busy(busy_a)
  );

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .sin_valid(sin_valid), .sin_data(sin_data), .sin_ready(sin_ready_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready),
    .busy(busy_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: words in delivery order, bits of the word being collected,
  // whether the output register is full, and whether a finished word waits.
  int exp_m[$];
  int exp_l[$];
  bit partial[$];
  bit out_valid = 1'b0;
  bit held = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a consume happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_valid_a && dout_ready) begin
        if (exp_m.size() == 0) begin
          checks++; errors++;
          $display("FAIL word_msb: got %b, expected no word", dout_a);
        end else begin
          $display("word msb-first %b (expected %b)", dout_a, W'(exp_m[0]));
          chk("word_msb", 32'(dout_a), 32'(exp_m.pop_front()));
        end
      end
      if (dout_valid_b && dout_ready) begin
        if (exp_l.size() == 0) begin
          checks++; errors++;
          $display("FAIL word_lsb: got %b, expected no word", dout_b);
        end else begin
          $display("word lsb-first %b (expected %b)", dout_b, W'(exp_l[0]));
          chk("word_lsb", 32'(dout_b), 32'(exp_l.pop_front()));
        end
      end
    end
  end

  task automatic check_status();
    chk("sin_ready_a", 32'(sin_ready_a), 32'(!held));
    chk("sin_ready_b", 32'(sin_ready_b), 32'(!held));
    chk("busy_a", 32'(busy_a), 32'((partial.size() != 0) || held));
    chk("busy_b", 32'(busy_b), 32'((partial.size() != 0) || held));
    chk("dout_valid_a", 32'(dout_valid_a), 32'(out_valid));
    chk("dout_valid_b", 32'(dout_valid_b), 32'(out_valid));
    if (out_valid) begin
      if (exp_m.size() == 0 || exp_l.size() == 0) begin
        checks++; errors++;
        $display("FAIL model_queue: got empty queue, expected a pending word");
      end else begin
        chk("dout_hold_a", 32'(dout_a), 32'(exp_m[0]));
        chk("dout_hold_b", 32'(dout_b), 32'(exp_l[0]));
      end
    end
  endtask

  task automatic check_reset_values();
    chk("rst_dout_a", 32'(dout_a), 32'd0);
    chk("rst_dout_b", 32'(dout_b), 32'd0);
    chk("rst_valid_a", 32'(dout_valid_a), 32'd0);
    chk("rst_valid_b", 32'(dout_valid_b), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    chk("rst_ready_a", 32'(sin_ready_a), 32'd1);
    chk("rst_ready_b", 32'(sin_ready_b), 32'd1);
  endtask

  // Drive one cycle, advance the model across the edge, then check status.
  task automatic step(input bit v, input bit d, input bit c, input bit r);
    bit consume;
    bit loaded;
    int wm;
    int wl;
    sin_valid  = v;
    sin_data   = d;
    clr        = c;
    dout_ready = r;
    @(posedge clk);
    consume = out_valid && r;
    loaded  = 1'b0;
    if (c) begin
      partial.delete();
      if (held) begin
        void'(exp_m.pop_back());
        void'(exp_l.pop_back());
        held = 1'b0;
      end
    end else if (held) begin
      if (consume) begin
        held   = 1'b0;
        loaded = 1'b1;
      end
    end else if (v) begin
      partial.push_back(d);
      if (partial.size() == W) begin
        wm = 0;
        wl = 0;
        for (int i = 0; i < W; i++) begin
          wm += int'(partial[i]) * (1 << (W - 1 - i));
          wl += int'(partial[i]) * (1 << i);
        end
        exp_m.push_back(wm);
        exp_l.push_back(wl);
        partial.delete();
        if (!out_valid || consume) loaded = 1'b1;
        else held = 1'b1;
      end
    end
    if (loaded) out_valid = 1'b1;
    else if (consume) out_valid = 1'b0;
    #1;
    check_status();
  endtask

  // Reset pulse strictly between clock edges.
  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_values();
    exp_m.delete();
    exp_l.delete();
    partial.delete();
    out_valid = 1'b0;
    held = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2 check_reset_values();
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three bits, consumer always ready
    step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1);
    chk("t1_dout_msb", 32'(dout_a), 32'(3'b101));
    step(0, 0, 0, 1);

    // Back-to-back words
    step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1);
    chk("t2_dout_lsb_1", 32'(dout_b), 32'(3'b101));
    step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 0, 0, 1);
    chk("t2_dout_lsb_2", 32'(dout_b), 32'(3'b010));
    step(0, 0, 0, 1);

    // Stall with consumer blocked, then release
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("t3_dout_held", 32'(dout_a), 32'(3'b001));
    chk("t3_stalled", 32'(sin_ready_a), 32'd0);
    step(0, 0, 0, 1);
    chk("t3_dout_next", 32'(dout_a), 32'(3'b110));
    step(0, 0, 0, 1);

    // Abort a partial word with clr while a bit is offered
    step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 1, 1);
    step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
    chk("t4_dout_msb", 32'(dout_a), 32'(3'b011));
    step(0, 0, 0, 1);

    // Asynchronous reset mid-word, then a full word
    step(1, 1, 0, 1);
    async_reset();
    step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 0, 0, 1);
    chk("t5_dout_msb", 32'(dout_a), 32'(3'b100));
    step(0, 0, 0, 1);

    // Gaps carrying random data must not disturb assembly
    step(1, 0, 0, 1); step(0, 1'($urandom), 0, 1); step(1, 1, 0, 1);
    step(0, 1'($urandom), 0, 1); step(1, 1, 0, 1);
    chk("t6_dout_msb", 32'(dout_a), 32'(3'b011));
    step(0, 0, 0, 1);

    // Randomized traffic with backpressure, aborts and occasional resets
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 31) == 0,
           $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    for (int n = 0; n < 4; n++) step(0, 0, 0, 1);
    chk("drain_msb", 32'(exp_m.size()), 32'd0);
    chk("drain_lsb", 32'(exp_l.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
